dabble_seq_ctrl: RTL

DABBLE_SEQ_CTRL -- requirements
Module: dabble_seq_ctrl

---
 rtl/dabble_seq_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/dabble_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, latency BIN_W cycles after accept.
// Result holds in DONE until out_ready; optional cancel input enabled by defining DABBLE_ABORT_EN.
module dabble_seq_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
`ifdef DABBLE_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    if (BIN_W < 4 || BIN_W > 16) begin : g_bad_width
        $error("dabble_seq_ctrl: BIN_W must be within 4..16");
    end
    if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
        $error("dabble_seq_ctrl: DIGITS too small to hold 2^BIN_W-1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [BIN_W-1:0]   sr;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_nxt;
    logic               abort_i;

`ifdef DABBLE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Add-3 stays inside each nibble: a digit of at most 9 becomes at most 12.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_nxt = {acc_adj[ACC_W-2:0], sr[BIN_W-1]};
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            sr      <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!abort_i && in_valid) begin
                        sr    <= bin_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        sr  <= {sr[BIN_W-2:0], 1'b0};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state   <= DONE;
                            bcd_out <= acc_nxt;
                        end
                    end
                end
                DONE: begin
                    if (abort_i || out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
